// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding and default memory geometry.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;
    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;
endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// arb_prio: combinational fetch/data winner select with a starvation counter.
module arb_prio #(
    parameter int STARVE_MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
    logic          starved;
    assign starved  = starve_cnt == SW'(STARVE_MAX);
    // Grants are forced low in reset so no RAM access leaks out.
    assign grant_if = rst_n & if_req & ~halt & (~d_req | starved);
    assign grant_d  = rst_n & d_req & ~grant_if;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (grant_if)
            starve_cnt <= '0;
        else if (grant_d && if_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between fetch and data requesters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   if_stall_cnt
);
    state_t state;
    logic   grant_if, grant_d;

    arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt     (halt),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    assign if_ack    = grant_if;
    assign d_ack     = grant_d;
    assign mem_en    = grant_if | grant_d;
    assign mem_we    = grant_d & d_we;
    assign mem_addr  = grant_d ? d_addr : if_addr;
    assign mem_wdata = d_wdata;
    assign if_rvalid = state == RD_IF;
    assign d_rvalid  = state == RD_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    // The state records which port owns the read returning next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            if_stall_cnt <= '0;
        end else begin
            state <= grant_if ? RD_IF : (grant_d && !d_we) ? RD_D : IDLE;
            if (if_req && !if_ack && !halt && if_stall_cnt != 16'hFFFF)
                if_stall_cnt <= if_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, read return, halt and reset.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          halt = 0;
    logic          if_req = 0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 0, d_we = 0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   if_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .if_stall_cnt(if_stall_cnt)
    );

    always #5 clk = ~clk;

    // Bench-side RAM: unwritten words read back a fixed address-derived pattern.
    logic [DW-1:0]    ram [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] written = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : pat(mem_addr);
            end
        end
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hA500_0000 + 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt [6] = '{0, 1, 2, 2, 3, 4};
        logic exp_d [6] = '{1, 1, 0, 1, 1, 0};

        // Reset: requests present, nothing granted, all outputs quiet.
        if_req = 1; d_req = 1;
        tick; tick;
        #1;
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        check("rst_stall", 32'(if_stall_cnt), 0);
        if_req = 0; d_req = 0;
        tick;
        rst_n = 1;

        // Fetch-only stream, first grant right after release.
        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = AW'(i);
            #1;
            check($sformatf("fetch_ack%0d", i), 32'(if_ack), 1);
            check($sformatf("fetch_addr%0d", i), 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, AW'(i)}));
            tick;
            check($sformatf("fetch_rvalid%0d", i), 32'({if_rvalid, d_rvalid}), 32'b10);
            check($sformatf("fetch_rdata%0d", i), if_rdata, pat(AW'(i)));
        end
        if_req = 0;
        #1;
        check("idle_mem_en", 32'({mem_en, mem_we}), 0);
        tick;
        check("fetch_drain", 32'(if_rvalid), 0);

        // Contention with STARVE_MAX=2: D,D,IF,D,D,IF.
        if_req = 1; if_addr = 10; d_req = 1; d_we = 0; d_addr = 20;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_d_ack%0d", i), 32'(d_ack), 32'(exp_d[i]));
            check($sformatf("cont_if_ack%0d", i), 32'(if_ack), 32'(!exp_d[i]));
            check($sformatf("cont_stall%0d", i), 32'(if_stall_cnt), 32'(exp_cnt[i]));
            tick;
            check($sformatf("cont_rdata%0d", i), mem_rdata, exp_d[i] ? pat(20) : pat(10));
            check($sformatf("cont_rv%0d", i), 32'({if_rvalid, d_rvalid}), exp_d[i] ? 32'b01 : 32'b10);
        end
        check("cont_stall_end", 32'(if_stall_cnt), 4);
        if_req = 0; d_req = 0;
        tick;

        // Store 7 to 200, then load 200 the next cycle.
        d_req = 1; d_we = 1; d_addr = 200; d_wdata = 7;
        #1;
        check("st_ack", 32'({d_ack, mem_en, mem_we}), 32'b111);
        check("st_wdata", mem_wdata, 7);
        tick;
        check("st_no_rvalid", 32'(d_rvalid), 0);
        d_we = 0;
        #1;
        check("ld_ack", 32'({d_ack, mem_we}), 32'b10);
        tick;
        check("ld_rvalid", 32'(d_rvalid), 1);
        check("ld_rdata", d_rdata, 7);
        d_req = 0;
        tick;

        // Halt: in-flight fetch returns, only data is served, stall count frozen.
        if_req = 1; if_addr = 5;
        #1;
        check("pre_halt_ack", 32'(if_ack), 1);
        tick;
        halt = 1; d_req = 1; d_addr = 30;
        #1;
        check("halt_if_rv", 32'(if_rvalid), 1);
        check("halt_if_rdata", if_rdata, pat(5));
        for (int i = 0; i < 2; i++) begin
            check($sformatf("halt_acks%0d", i), 32'({if_ack, d_ack}), 32'b01);
            tick;
            check($sformatf("halt_d_rv%0d", i), 32'({if_rvalid, d_rvalid}), 32'b01);
            check($sformatf("halt_d_rdata%0d", i), d_rdata, pat(30));
            check($sformatf("halt_stall%0d", i), 32'(if_stall_cnt), 4);
        end
        halt = 0;
        #1;
        check("unhalt_starved_if", 32'({if_ack, d_ack}), 32'b10);
        if_req = 0; d_req = 0;
        tick;

        // Reset with a load in flight: the read is discarded.
        d_req = 1; d_addr = 40;
        #1;
        check("rl_ack", 32'(d_ack), 1);
        tick;
        d_req = 0;
        rst_n = 0;
        #1;
        check("rl_rvalid_dropped", 32'(d_rvalid), 0);
        check("rl_stall_clr", 32'(if_stall_cnt), 0);
        d_req = 1; d_addr = 41;
        #1;
        check("rl_ack_in_rst", 32'({d_ack, mem_en}), 0);
        tick;
        check("rl_no_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        rst_n = 1;
        #1;
        check("rl_first_grant", 32'(d_ack), 1);
        tick;
        check("rl_post_rv", 32'(d_rvalid), 1);
        check("rl_post_rdata", d_rdata, pat(41));
        d_req = 0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
